// File: rtl/csa_resolver.sv
// Multi-cycle carry-propagate adder: resolves a carry-save pair into one binary word,
// CHUNK bits per clock LSB first, with valid/ready handshakes on both sides.
module csa_resolver #(
    parameter int NN    = 17,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NN-1:0] in1,
    input  logic [NN-1:0] in2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NN-1:0] sum,
    output logic          cout
);

    localparam int NCH = (NN + CHUNK - 1) / CHUNK;
    localparam int W   = NCH * CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    res_q, res_d;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic [NN-1:0]   sum_q;
    logic            cout_q, cout_d;
    logic [CHUNK:0]  chunk_sum;
    logic            last_chunk;

    assign last_chunk = (cnt_q == CW'(NCH - 1));

    // Operands shift right one chunk per cycle, so the active chunk is always at bit 0
    // and the resolved chunk enters the result register from the top.
    always_comb begin
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        res_d     = W'({chunk_sum[CHUNK-1:0], res_q} >> CHUNK);
    end

    // With no padding the true carry is the final chunk carry; otherwise it lands in
    // the first padded result bit and the chunk carry is always zero.
    if (W == NN) begin : g_cout_carry
        assign cout_d = chunk_sum[CHUNK];
    end else begin : g_cout_pad
        assign cout_d = res_d[NN];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: default assignment first so no path through the case leaves state_d
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= W'(in1);
                        b_q     <= W'(in2);
                        res_q   <= '0;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    res_q   <= res_d;
                    carry_q <= chunk_sum[CHUNK];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        sum_q  <= res_d[NN-1:0];
                        cout_q <= cout_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: directed cases, random stream, CHUNK sweep,
// all compared against a plain-arithmetic reference sum.
module tb_csa_resolver;

    localparam int NN = 17;
    localparam int SW_NCH [3] = '{17, 4, 1};

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, cout;
    logic [NN-1:0] in1, in2, sum;

    logic          sw_in_valid;
    logic [NN-1:0] sw_in1, sw_in2;
    logic          sw_ir   [3];
    logic          sw_ov   [3];
    logic [NN-1:0] sw_sum  [3];
    logic          sw_cout [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csa_resolver #(.NN(NN), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    csa_resolver #(.NN(NN), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ir[0]),
        .in1(sw_in1), .in2(sw_in2), .out_valid(sw_ov[0]), .out_ready(1'b1),
        .sum(sw_sum[0]), .cout(sw_cout[0])
    );

    csa_resolver #(.NN(NN), .CHUNK(5)) dut_c5 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ir[1]),
        .in1(sw_in1), .in2(sw_in2), .out_valid(sw_ov[1]), .out_ready(1'b1),
        .sum(sw_sum[1]), .cout(sw_cout[1])
    );

    csa_resolver #(.NN(NN), .CHUNK(17)) dut_c17 (
        .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_ir[2]),
        .in1(sw_in1), .in2(sw_in2), .out_valid(sw_ov[2]), .out_ready(1'b1),
        .sum(sw_sum[2]), .cout(sw_cout[2])
    );

    function automatic logic [NN:0] ref_add(input logic [NN-1:0] x, input logic [NN-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a pair for one accepting edge, scramble the inputs, then count edges until out_valid.
    task automatic run_pair(input logic [NN-1:0] x, input logic [NN-1:0] y, output int lat);
        in1      = x;
        in2      = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in1      = NN'($urandom);
        in2      = NN'($urandom);
        lat      = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic sweep(input logic [NN-1:0] x, input logic [NN-1:0] y);
        logic [NN:0] e;
        int          seen [3];
        e = ref_add(x, y);
        for (int i = 0; i < 3; i++) begin
            seen[i] = -1;
            check($sformatf("sw%0d_ready", i), 32'(sw_ir[i]), 32'd1);
        end
        sw_in1      = x;
        sw_in2      = y;
        sw_in_valid = 1'b1;
        tick();
        sw_in_valid = 1'b0;
        sw_in1      = NN'($urandom);
        sw_in2      = NN'($urandom);
        for (int n = 1; n <= 22; n++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (sw_ov[i] && seen[i] < 0) begin
                    seen[i] = n;
                    check($sformatf("sw%0d_sum", i), 32'(sw_sum[i]), 32'(e[NN-1:0]));
                    check($sformatf("sw%0d_cout", i), 32'(sw_cout[i]), 32'(e[NN]));
                end
            end
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("sw%0d_latency", i), 32'(seen[i]), 32'(SW_NCH[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        logic [NN-1:0] x, y;
        logic [NN:0]   e;
        logic [NN:0]   q [$];
        int            got, cyc, last;

        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in1         = '0;
        in2         = '0;
        sw_in_valid = 1'b0;
        sw_in1      = '0;
        sw_in2      = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        // Full carry ripple through every chunk.
        run_pair(17'h1FFFF, 17'h00001, lat);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_sum", 32'(sum), 32'd0);
        check("t1_cout", 32'(cout), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("t1_drop_valid", 32'(out_valid), 32'd0);
        check("t1_idle_ready", 32'(in_ready), 32'd1);
        check("t1_retain_cout", 32'(cout), 32'd1);
        out_ready = 1'b0;

        // Compressor-tree pair for 5+7+9.
        run_pair(17'h0000B, 17'h0000A, lat);
        check("t2_latency", 32'(lat), 32'd5);
        check("t2_sum", 32'(sum), 32'd21);
        check("t2_cout", 32'(cout), 32'd0);

        // Backpressure in DONE with noisy inputs.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            in1      = NN'($urandom);
            in2      = NN'($urandom);
            tick();
            check("t3_sum", 32'(sum), 32'd21);
            check("t3_cout", 32'(cout), 32'd0);
            check("t3_out_valid", 32'(out_valid), 32'd1);
            check("t3_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t3_release_valid", 32'(out_valid), 32'd0);
        check("t3_release_ready", 32'(in_ready), 32'd1);
        repeat (7) tick();
        check("t3_no_accept", 32'(out_valid), 32'd0);
        check("t3_retain_sum", 32'(sum), 32'd21);
        out_ready = 1'b0;

        // Reset pulse in the third RUN cycle.
        in1      = NN'($urandom);
        in2      = NN'($urandom);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("t4_in_run", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_valid", 32'(out_valid), 32'd0);
        check("t4_rst_sum", 32'(sum), 32'd0);
        check("t4_rst_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b0;
        tick();
        x = NN'($urandom);
        y = NN'($urandom);
        e = ref_add(x, y);
        run_pair(x, y, lat);
        check("t4_latency", 32'(lat), 32'd5);
        check("t4_sum", 32'(sum), 32'(e[NN-1:0]));
        check("t4_cout", 32'(cout), 32'(e[NN]));

        // Reset while a result waits in DONE.
        #2 rst = 1'b1;
        #1;
        check("t4_done_rst_valid", 32'(out_valid), 32'd0);
        check("t4_done_rst_cout", 32'(cout), 32'd0);
        #2 rst = 1'b0;
        tick();

        // Back-to-back stream with both handshakes tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        got       = 0;
        cyc       = 0;
        last      = -1;
        check("t5_start_ready", 32'(in_ready), 32'd1);
        while (got < 100 && cyc < 1000) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("t5_spurious_result", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("t5_sum", 32'(sum), 32'(e[NN-1:0]));
                    check("t5_cout", 32'(cout), 32'(e[NN]));
                end
                if (last >= 0)
                    check("t5_period", 32'(cyc - last), 32'd7);
                last = cyc;
                got++;
            end
            in1 = NN'($urandom);
            in2 = NN'($urandom);
            if (in_ready)
                q.push_back(ref_add(in1, in2));
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("t5_count", 32'(got), 32'd100);
        repeat (8) tick();

        // CHUNK sweep: 1, 5, 17.
        sweep(17'h1FFFF, 17'h1FFFF);
        sweep(17'h1FFFF, 17'h00001);
        sweep(17'h00000, 17'h00000);
        for (int i = 0; i < 6; i++)
            sweep(NN'($urandom), NN'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
